imem_fill: RTL and testbench



---
 rtl/imem_fill_pkg.sv | 22 ++
 rtl/imem_fill_if.sv | 24 ++
 rtl/imem_fill.sv | 110 +++++++++++
 tb/tb_imem_fill.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/imem_fill_pkg.sv
// Shared constants, FSM encoding and helpers for the I-cache line-refill responder.
// The optional last-line buffer is enabled with the IMEM_FILL_LBUF_EN macro.
package imem_fill_pkg;
  localparam int LINE_W = 512;
  localparam int WORD_W = 64;
  localparam int BEATS  = LINE_W / WORD_W;
  localparam int CNT_W  = $clog2(BEATS);
  localparam int OFFS   = $clog2(LINE_W / 8);
  localparam int WORD_B = WORD_W / 8;
  localparam int TAG_W  = 64 - OFFS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DONE  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  function automatic logic [63:0] line_base(input logic [63:0] a);
    return {a[63:OFFS], {OFFS{1'b0}}};
  endfunction
endpackage

// File: rtl/imem_fill_if.sv
// Refill bus bundle: cache-side line request/return plus the word-wide memory port.
// slave = the responder (imem_fill), master = the cache/memory environment.
interface imem_fill_if;
  import imem_fill_pkg::*;

  logic [63:0]       b_addr_i;
  logic              b_rd_i;
  logic [LINE_W-1:0] b_data_i;
  logic              b_dv_i;
  logic [63:0]       m_addr;
  logic              m_rd;
  logic [WORD_W-1:0] m_data;
  logic              m_ack;

  modport slave (
    input  b_addr_i, b_rd_i, m_data, m_ack,
    output b_data_i, b_dv_i, m_addr, m_rd
  );

  modport master (
    output b_addr_i, b_rd_i, m_data, m_ack,
    input  b_data_i, b_dv_i, m_addr, m_rd
  );
endinterface

// File: rtl/imem_fill.sv
// Line-refill responder: fetches a cache line over BEATS word reads and returns it
// with a one-cycle b_dv_i pulse. IMEM_FILL_LBUF_EN adds a one-entry last-line hit path.
module imem_fill
  import imem_fill_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  imem_fill_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  state_e            state_q, state_d;
  logic [63:0]       base_q, base_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [63:0]       req_base;

  assign req_base     = line_base(bus.b_addr_i);
  assign bus.m_addr   = base_q + 64'(WORD_B) * 64'(cnt_q);
  assign bus.b_data_i = line_q;

`ifdef IMEM_FILL_LBUF_EN
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             vld_q, vld_d;
  logic             hit;

  assign hit = vld_q && (tag_q == req_base[63:OFFS]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '0;
      vld_q <= 1'b0;
    end else begin
      tag_q <= tag_d;
      vld_q <= vld_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    cnt_d      = cnt_q;
    line_d     = line_q;
    bus.m_rd   = 1'b0;
    bus.b_dv_i = 1'b0;
`ifdef IMEM_FILL_LBUF_EN
    tag_d      = tag_q;
    vld_d      = vld_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.b_rd_i) begin
          base_d  = req_base;
          cnt_d   = '0;
          state_d = S_REQ;
`ifdef IMEM_FILL_LBUF_EN
          if (hit) state_d = S_DONE;
`endif
        end
      end
      S_REQ: begin
        bus.m_rd = 1'b1;
        if (!bus.b_rd_i) begin
          // Aborted fill: an ack in this same cycle closes the transfer, otherwise drain it.
          state_d = bus.m_ack ? S_IDLE : S_DRAIN;
`ifdef IMEM_FILL_LBUF_EN
          vld_d   = 1'b0;
`endif
        end else if (bus.m_ack) begin
          line_d[WORD_W*cnt_q +: WORD_W] = bus.m_data;
          cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = S_DONE;
`ifdef IMEM_FILL_LBUF_EN
          if (cnt_q == '0) vld_d = 1'b0;
`endif
        end
      end
      S_DONE: begin
        bus.b_dv_i = 1'b1;
        state_d    = S_IDLE;
`ifdef IMEM_FILL_LBUF_EN
        tag_d      = base_q[63:OFFS];
        vld_d      = 1'b1;
`endif
      end
      S_DRAIN: begin
        bus.m_rd = 1'b1;
        if (bus.m_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_fill.sv
// Directed bench for imem_fill: table of fills with varying wait patterns plus
// hand sequences for abort, async reset and the optional last-line buffer.
module tb_imem_fill;
  import imem_fill_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   per = 1;
  int   k = 0;

  imem_fill_if bus ();

  imem_fill dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [63:0] memword(input logic [63:0] a);
    return {a[31:0] ^ 32'hDEADBEEF, a[31:0] + 32'h01234567};
  endfunction

  // Memory model: ack on every per-th cycle of an active strobe, data from address.
  always @(posedge clk) begin
    #1;
    if (bus.m_rd) k = k + 1;
    else k = 0;
    bus.m_ack  = (per <= 1) ? 1'b1 : (bus.m_rd && (k % per == 0));
    bus.m_data = memword(bus.m_addr);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_line(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_fill(input logic [63:0] addr, input int p, input logic [63:0] eb,
                          input int lat, input string nm);
    logic [LINE_W-1:0] exp_line;
    logic [LINE_W-1:0] got_line;
    int cyc, acks, dv_cyc;
    bit addr_ok, mrd_seen;
    for (int i = 0; i < BEATS; i++)
      exp_line[WORD_W*i +: WORD_W] = memword(eb + 64'(WORD_B * i));
    @(negedge clk);
    per = p;
    bus.b_addr_i = addr;
    bus.b_rd_i   = 1'b1;
    @(posedge clk);
    cyc = 0; acks = 0; dv_cyc = -1; addr_ok = 1'b1; mrd_seen = 1'b0;
    got_line = '0;
    while (dv_cyc < 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      bus.b_addr_i = addr ^ 64'h0000_0000_0055_5000;
      if (bus.b_dv_i) begin
        dv_cyc   = cyc;
        got_line = bus.b_data_i;
        bus.b_rd_i = 1'b0;
      end else if (bus.m_rd) begin
        mrd_seen = 1'b1;
        if (bus.m_addr !== eb + 64'(WORD_B * acks)) addr_ok = 1'b0;
        if (bus.m_ack) acks++;
      end
    end
    bus.b_rd_i = 1'b0;
    chk({nm, " latency"}, 64'(dv_cyc), 64'(lat));
    chk({nm, " addr_seq"}, 64'(addr_ok), 64'd1);
    chk({nm, " m_rd_used"}, 64'(mrd_seen), 64'(lat > 1));
    chk_line({nm, " line"}, got_line, exp_line);
    @(negedge clk);
    chk({nm, " dv_single"}, 64'(bus.b_dv_i), 64'd0);
  endtask

  typedef struct {
    logic [63:0] addr;
    int          per;
    logic [63:0] base;
    int          lat;
  } vec_t;

  vec_t vt[5];
  int   m_rd_at[16];
  bit   dv_seen;

  initial begin
    vt[0] = '{64'h1000, 1, 64'h1000, 9};
    vt[1] = '{64'h2040, 3, 64'h2040, 25};
    vt[2] = '{64'h1006, 1, 64'h1000, 9};
    vt[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 2, 64'hFFFF_FFFF_FFFF_FFC0, 17};
    vt[4] = '{64'h3000, 1, 64'h3000, 9};

    bus.b_addr_i = '0;
    bus.b_rd_i   = 1'b0;
    bus.m_ack    = 1'b0;
    bus.m_data   = '0;
    #12;
    chk("rst m_rd", 64'(bus.m_rd), 64'd0);
    chk("rst b_dv", 64'(bus.b_dv_i), 64'd0);
    chk("rst m_addr", bus.m_addr, 64'd0);
    chk_line("rst b_data", bus.b_data_i, '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++)
      run_fill(vt[i].addr, vt[i].per, vt[i].base, vt[i].lat, $sformatf("vec%0d", i));

    // Abort with beat 4 pending; its ack lands two cycles after b_rd_i drops.
    @(negedge clk);
    per = 3; bus.b_addr_i = 64'h5000; bus.b_rd_i = 1'b1;
    @(posedge clk);
    dv_seen = 1'b0;
    for (int c = 1; c < 16; c++) begin
      @(negedge clk);
      m_rd_at[c] = int'(bus.m_rd);
      if (bus.b_dv_i) dv_seen = 1'b1;
      if (c == 10) bus.b_rd_i = 1'b0;
    end
    chk("abort m_rd c11", 64'(m_rd_at[11]), 64'd1);
    chk("abort m_rd c12", 64'(m_rd_at[12]), 64'd1);
    chk("abort m_rd c13", 64'(m_rd_at[13]), 64'd0);
    chk("abort no dv", 64'(dv_seen), 64'd0);
    run_fill(64'h3000, 1, 64'h3000, 9, "post_abort");

    // Abort coinciding with an ack goes straight back to idle.
    @(negedge clk);
    per = 1; bus.b_addr_i = 64'h6000; bus.b_rd_i = 1'b1;
    @(posedge clk);
    dv_seen = 1'b0;
    for (int c = 1; c < 8; c++) begin
      @(negedge clk);
      m_rd_at[c] = int'(bus.m_rd);
      if (bus.b_dv_i) dv_seen = 1'b1;
      if (c == 3) bus.b_rd_i = 1'b0;
    end
    chk("abort_ack m_rd c3", 64'(m_rd_at[3]), 64'd1);
    chk("abort_ack m_rd c4", 64'(m_rd_at[4]), 64'd0);
    chk("abort_ack no dv", 64'(dv_seen), 64'd0);

    // Asynchronous reset between edges mid-fill.
    @(negedge clk);
    per = 1; bus.b_addr_i = 64'h7000; bus.b_rd_i = 1'b1;
    @(posedge clk);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst m_rd", 64'(bus.m_rd), 64'd0);
    chk("arst b_dv", 64'(bus.b_dv_i), 64'd0);
    chk("arst m_addr", bus.m_addr, 64'd0);
    chk_line("arst b_data", bus.b_data_i, '0);
    bus.b_rd_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_fill(64'h7000, 1, 64'h7000, 9, "post_rst");

    // Re-request of the same line, then a neighbouring line.
    run_fill(64'h1000, 1, 64'h1000, 9, "lb_fill");
`ifdef IMEM_FILL_LBUF_EN
    run_fill(64'h1000, 1, 64'h1000, 1, "lb_hit");
`else
    run_fill(64'h1000, 1, 64'h1000, 9, "lb_hit");
`endif
    run_fill(64'h1040, 1, 64'h1040, 9, "lb_miss");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
